// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM slave: programmable wait states, byte/halfword/word
// writes with little-endian lane enables, two-cycle ERROR response and
// write-to-read forwarding for back-to-back accesses to the same word.
module ahb_sram_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic                 HREADY,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int                   LP_AW    = $clog2(MEM_DEPTH);
  localparam int                   LP_LANES = DATAWIDTH / 8;
  localparam logic [ADDRWIDTH-1:0] LP_LIMIT = ADDRWIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0]           LP_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;

  // Pending OKAY data phase captured at address acceptance
  logic                   r_dp_valid;
  logic                   r_dp_write;
  logic [LP_AW-1:0]       r_dp_idx;
  logic [LP_LANES-1:0]    r_dp_be;

  logic [DATAWIDTH-1:0]   r_mem [MEM_DEPTH];
  logic [DATAWIDTH-1:0]   r_hrdata;

  logic                   w_open;
  logic                   w_accept;
  logic                   w_err;
  logic                   w_acc_ok;
  logic                   w_acc_err;
  logic [LP_AW-1:0]       w_idx;
  logic [LP_LANES-1:0]    w_be;
  logic                   w_wr_en;
  logic                   w_rd_now;
  logic                   w_rd_wait;
  logic [LP_AW-1:0]       w_rd_idx;
  logic                   w_fwd;
  logic [DATAWIDTH-1:0]   w_rd_word;
  logic [DATAWIDTH-1:0]   w_rd_merged;
  logic                   w_unused;

  // Sideband attributes carry no meaning for a plain memory
  assign w_unused = &{1'b0, HTRANS[0], HBURST, HPROT, HMASTLOCK};

  // A new address phase can only be taken while our own ready is high
  assign w_open   = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept = HSEL & HREADY & HTRANS[1] & w_open;
  assign w_err    = (HSIZE > 3'd2)
                  || ((HSIZE == 3'd1) && HADDR[0])
                  || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                  || (HADDR >= LP_LIMIT);
  assign w_acc_ok  = w_accept & ~w_err;
  assign w_acc_err = w_accept & w_err;
  assign w_idx     = HADDR[LP_AW+1:2];

  // Little-endian lane enables from transfer size and low address bits
  always_comb begin
    w_be = '1;
    case (HSIZE)
      3'd0:    w_be = 4'b0001 << HADDR[1:0];
      3'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_be = '1;
    endcase
  end

  // Data phase ends on a ready cycle in IDLE; error phases never set r_dp_valid
  assign w_wr_en = r_dp_valid & r_dp_write & (r_state == S_IDLE);

  // Read word is captured on the edge before the ready cycle of a read phase:
  // at acceptance with no wait states, otherwise on the last wait cycle
  assign w_rd_now  = w_acc_ok & ~HWRITE & (LP_WAIT == 4'd0);
  assign w_rd_wait = (r_state == S_WAIT) & (r_cnt == 4'd1) & ~r_dp_write;
  assign w_rd_idx  = w_rd_wait ? r_dp_idx : w_idx;
  assign w_rd_word = r_mem[w_rd_idx];
  assign w_fwd     = w_wr_en & (r_dp_idx == w_rd_idx);

  // Forward bytes of a write landing on the same edge into the captured word
  for (genvar gi = 0; gi < LP_LANES; gi++) begin : g_lane
    assign w_rd_merged[gi*8 +: 8] = (w_fwd && r_dp_be[gi]) ? HWDATA[gi*8 +: 8]
                                                             : w_rd_word[gi*8 +: 8];
  end

  // Next-state and response outputs of the data-phase FSM
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    HREADYOUT    = 1'b1;
    HRESP        = 1'b0;
    case (r_state)
      S_IDLE, S_ERR2: begin
        HRESP = (r_state == S_ERR2);
        if (w_acc_err) begin
          w_state_next = S_ERR1;
        end else if (w_acc_ok && (LP_WAIT != 4'd0)) begin
          w_state_next = S_WAIT;
          w_cnt_next   = LP_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        HREADYOUT  = 1'b0;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_IDLE;
        end
      end
      S_ERR1: begin
        HREADYOUT    = 1'b0;
        HRESP        = 1'b1;
        w_state_next = S_ERR2;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the address phase into data-phase registers when the bus is open
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_be    <= '0;
    end else if (w_open) begin
      r_dp_valid <= w_acc_ok;
      if (w_accept) begin
        r_dp_write <= HWRITE;
        r_dp_idx   <= w_idx;
        r_dp_be    <= w_be;
      end
    end
  end

  // Read data register: zero for error phases, held otherwise
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_hrdata <= '0;
    end else if (w_acc_err) begin
      r_hrdata <= '0;
    end else if (w_rd_now || w_rd_wait) begin
      r_hrdata <= w_rd_merged;
    end
  end

  // Byte-lane memory write on the edge that ends an OKAY write phase
  always_ff @(posedge HCLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < LP_LANES; i++) begin
        if (r_dp_be[i]) begin
          r_mem[r_dp_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
        end
      end
    end
  end

  assign HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 2 wait states) exercised in turn
// against a transaction-level model of bus timing and a byte-addressed memory.
module tb_ahb_sram_slave;

  localparam int DEPTH = 256;
  localparam int LIMIT = 4 * DEPTH;

  logic        clk;
  logic        rst_a       [2];
  logic        hsel_a      [2];
  logic [31:0] haddr_a     [2];
  logic [1:0]  htrans_a    [2];
  logic        hwrite_a    [2];
  logic [2:0]  hsize_a     [2];
  logic        hready_a    [2];
  logic [31:0] hwdata_a    [2];
  logic [31:0] hrdata_a    [2];
  logic        hreadyout_a [2];
  logic        hresp_a     [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst_a[0]), .HSEL(hsel_a[0]), .HADDR(haddr_a[0]),
    .HTRANS(htrans_a[0]), .HWRITE(hwrite_a[0]), .HSIZE(hsize_a[0]),
    .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0), .HREADY(hready_a[0]),
    .HWDATA(hwdata_a[0]), .HRDATA(hrdata_a[0]), .HREADYOUT(hreadyout_a[0]),
    .HRESP(hresp_a[0])
  );

  ahb_sram_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESET(rst_a[1]), .HSEL(hsel_a[1]), .HADDR(haddr_a[1]),
    .HTRANS(htrans_a[1]), .HWRITE(hwrite_a[1]), .HSIZE(hsize_a[1]),
    .HBURST(3'b001), .HPROT(4'b1111), .HMASTLOCK(1'b1), .HREADY(hready_a[1]),
    .HWDATA(hwdata_a[1]), .HRDATA(hrdata_a[1]), .HREADYOUT(hreadyout_a[1]),
    .HRESP(hresp_a[1])
  );

  int n_vec;
  int n_miss;
  int k;
  int wst;

  // Model state: memory as bytes, current data phase as a transaction
  logic [7:0]  mm [256];
  int          m_kind;   // 0 none, 1 OKAY, 2 ERROR
  int          m_left;   // data-phase cycles remaining including the current one
  bit          m_write;
  int unsigned m_addr;
  int unsigned m_size;
  logic [31:0] m_hrdata;
  bit          e_ready;
  bit          e_resp;
  bit          accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (ws=%0d t=%0t): got %h expected %h", name, wst, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int unsigned a);
    int unsigned b;
    b = a & ~32'd3;
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  function automatic bit is_bad(input int unsigned a, input int unsigned sz);
    if (sz > 2) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    return a >= LIMIT;
  endfunction

  // Expected outputs for the cycle now starting
  task automatic model_expect();
    if (m_kind == 0) begin
      e_ready = 1'b1;
      e_resp  = 1'b0;
    end else if (m_kind == 1) begin
      e_ready = (m_left == 1);
      e_resp  = 1'b0;
      if (e_ready && !m_write) m_hrdata = word_at(m_addr);
    end else begin
      e_ready  = (m_left == 1);
      e_resp   = 1'b1;
      m_hrdata = 32'h0;
    end
  endtask

  // One bus cycle: called at a negedge, returns at the next negedge
  task automatic cycle(input bit sel, input bit [1:0] trans, input bit write,
                       input logic [31:0] addr, input bit [2:0] size, input logic [31:0] wdata);
    model_expect();
    check("hreadyout", 32'(hreadyout_a[k]), 32'(e_ready));
    check("hresp", 32'(hresp_a[k]), 32'(e_resp));
    check("hrdata", hrdata_a[k], m_hrdata);
    hsel_a[k]   = sel;
    htrans_a[k] = trans;
    hwrite_a[k] = write;
    haddr_a[k]  = addr;
    hsize_a[k]  = size;
    hready_a[k] = e_ready;
    hwdata_a[k] = wdata;
    @(posedge clk);
    if (m_kind != 0) begin
      if (m_left == 1) begin
        if (m_kind == 1 && m_write) begin
          for (int b = 0; b < (1 << m_size); b++) begin
            if (m_addr + b < 256) mm[m_addr+b] = wdata[8*((m_addr+b)%4) +: 8];
          end
        end
        m_kind = 0;
      end else begin
        m_left--;
      end
    end
    accepted = e_ready && sel && trans[1];
    if (accepted) begin
      if (is_bad(addr, 32'(size))) begin
        m_kind = 2;
        m_left = 2;
      end else begin
        m_kind  = 1;
        m_left  = wst + 1;
        m_write = write;
        m_addr  = addr;
        m_size  = 32'(size);
      end
    end
    @(negedge clk);
  endtask

  // Hold an address phase until the model says it is taken
  task automatic issue(input bit sel, input bit [1:0] trans, input bit write,
                       input logic [31:0] addr, input bit [2:0] size, input logic [31:0] wdata);
    int n;
    n = 0;
    do begin
      cycle(sel, trans, write, addr, size, wdata);
      n++;
    end while (sel && trans[1] && !accepted && n < 40);
    if (sel && trans[1] && !accepted) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout (ws=%0d): got not-accepted expected accepted", wst);
    end
  endtask

  task automatic drain(input logic [31:0] wdata);
    int n;
    n = 0;
    while (m_kind != 0 && n < 40) begin
      cycle(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, wdata);
      n++;
    end
  endtask

  task automatic run_plan();
    // Reset state, still held in reset
    check("reset_ready", 32'(hreadyout_a[k]), 32'h1);
    check("reset_resp", 32'(hresp_a[k]), 32'h0);
    check("reset_rdata", hrdata_a[k], 32'h0);
    rst_a[k] = 1'b0;
    m_kind = 0; m_left = 0; m_hrdata = 32'h0;
    for (int i = 0; i < 256; i++) mm[i] = 8'hxx;

    // Preload bytes 0..63 with zero
    for (int i = 0; i < 16; i++) issue(1'b1, 2'b10, 1'b1, 32'(4*i), 3'd2, 32'h0);
    drain(32'h0);

    // Word write then back-to-back read of the same word
    issue(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'hDEADBEEF);
    drain(32'h0);
    check("raw_word", hrdata_a[k], 32'hDEADBEEF);

    // Byte then halfword writes, read back the whole word
    issue(1'b1, 2'b10, 1'b1, 32'h21, 3'd0, 32'h0);
    issue(1'b1, 2'b11, 1'b1, 32'h22, 3'd1, 32'h1234AA56);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'hBBCC7788);
    drain(32'h0);
    check("byte_half", hrdata_a[k], 32'hBBCCAA00);

    // Misaligned word and out-of-range write: ERROR, memory untouched
    issue(1'b1, 2'b10, 1'b1, 32'h13, 3'd2, 32'h0);
    check("err1_ready", 32'(hreadyout_a[k]), 32'h0);
    check("err1_resp", 32'(hresp_a[k]), 32'h1);
    issue(1'b1, 2'b10, 1'b1, 32'(LIMIT), 3'd2, 32'hFFFFFFFF);
    check("err2_ready", 32'(hreadyout_a[k]), 32'h0);
    check("err2_rdata", hrdata_a[k], 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'hFFFFFFFF);
    drain(32'h55555555);
    check("err_nowrite", hrdata_a[k], 32'hDEADBEEF);

    // BUSY/IDLE with HSEL, NONSEQ without HSEL: no access
    issue(1'b1, 2'b01, 1'b1, 32'h10, 3'd2, 32'h0);
    issue(1'b1, 2'b00, 1'b1, 32'h10, 3'd2, 32'h11111111);
    issue(1'b0, 2'b10, 1'b1, 32'h10, 3'd2, 32'h22222222);
    issue(1'b1, 2'b00, 1'b0, 32'h0, 3'd2, 32'h33333333);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h44444444);
    drain(32'h0);
    check("noxfer_nowrite", hrdata_a[k], 32'hDEADBEEF);

    // Reset in the middle of a write data phase
    issue(1'b1, 2'b10, 1'b1, 32'h30, 3'd2, 32'h0);
    hsel_a[k] = 1'b0; htrans_a[k] = 2'b00; hwdata_a[k] = 32'hCAFEF00D; hready_a[k] = 1'b1;
    #2 rst_a[k] = 1'b1;
    #1;
    check("midrst_ready", 32'(hreadyout_a[k]), 32'h1);
    check("midrst_resp", 32'(hresp_a[k]), 32'h0);
    check("midrst_rdata", hrdata_a[k], 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_a[k] = 1'b0;
    m_kind = 0; m_left = 0; m_hrdata = 32'h0;
    issue(1'b1, 2'b10, 1'b0, 32'h30, 3'd2, 32'h0);
    drain(32'h0);
    check("midrst_nowrite", hrdata_a[k], 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit          sel;
      bit [1:0]    trans;
      bit [2:0]    size;
      logic [31:0] addr;
      int unsigned r;
      sel   = ($urandom % 8) != 0;
      trans = 2'($urandom % 4);
      size  = (($urandom % 16) < 13) ? 3'($urandom % 3) : 3'(3 + $urandom % 5);
      r     = $urandom % 10;
      if (r < 8)       addr = 32'($urandom % 64);
      else if (r == 8) addr = 32'(LIMIT + $urandom % 64);
      else             addr = {1'b1, 31'($urandom)};
      cycle(sel, trans, 1'($urandom % 2), addr, size, 32'($urandom));
    end
    drain(32'h0);
    cycle(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; hsel_a[i] = 1'b0; haddr_a[i] = '0; htrans_a[i] = 2'b00;
      hwrite_a[i] = 1'b0; hsize_a[i] = 3'd2; hready_a[i] = 1'b1; hwdata_a[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      k   = i;
      wst = (i == 0) ? 0 : 2;
      run_plan();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
